sin_src: RTL and testbench

SIN_SRC -- requirements
Module: sin_src

---
 rtl/sin_src.sv | 53 +++++
 tb/tb_sin_src.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sin_src.sv
// Purpose : behavioural sine source driven by a phase accumulator. Real-valued output for analog/mixed-signal models.
// Latency : zero edges from phase update to out. The sample for the new phase appears on the same edge.
// Backpressure: none. en gates advancement; when en is low, phase and out hold.
//
// Ports:
//   clk - single clock; all state updates on its rising edge
//   rst - synchronous active-high reset; phase -> 0, out -> OFFSET
//   en  - advance enable; each enabled edge steps phase by PHASE_INC
//   out - OFFSET + AMPLITUDE*sin(2*pi*phase/2^PHASE_BITS), in volts
module sin_src #(
    parameter real                   AMPLITUDE  = 1.0,
    parameter real                   OFFSET     = 0.0,
    parameter int unsigned           PHASE_BITS = 32,
    parameter logic [PHASE_BITS-1:0] PHASE_INC  = PHASE_BITS'(42949673)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output real  out
);

    localparam real TWO_PI     = 6.283185307179586;
    localparam real PHASE_SPAN = 2.0 ** PHASE_BITS;

    logic [PHASE_BITS-1:0] phase;
    logic [PHASE_BITS-1:0] phase_next;
    logic [63:0]           phase_wide;

    // Registered deviation from OFFSET. A real variable starts at 0.0, so out
    // reads OFFSET before the first edge without an initialiser.
    real dev_q;

    // Wraps modulo 2^PHASE_BITS through natural vector truncation.
    always_comb begin
        phase_next = phase + PHASE_INC;
        // Zero-extend so the conversion to real always treats phase as unsigned.
        phase_wide = 64'(phase_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            dev_q <= 0.0;
        end else if (en) begin
            phase <= phase_next;
            dev_q <= AMPLITUDE * $sin(TWO_PI * real'(phase_wide) / PHASE_SPAN);
        end
    end

    // Adding a constant to the registered deviation keeps out edge-aligned.
    assign out = OFFSET + dev_q;

endmodule

// File: tb/tb_sin_src.sv
`timescale 1ps/1ps
module tb_sin_src;

    localparam logic [63:0] INC = 64'd42949673;

    logic clk = 1'b0;
    logic rst;
    logic en;
    real  out_a;
    real  out_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sin_src u_dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .out (out_a)
    );

    sin_src #(
        .AMPLITUDE (0.5),
        .OFFSET    (0.9)
    ) u_dut_scl (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .out (out_b)
    );

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    // Reference sample k after reset, using the closed-form phase k*INC mod 2^32.
    function automatic real model(input int k, input real amp, input real ofs);
        logic [63:0] prod;
        logic [63:0] ph;
        prod = 64'(k) * INC;
        ph   = {32'd0, prod[31:0]};
        return ofs + amp * $sin(6.283185307179586 * real'(ph) / 4294967296.0);
    endfunction

    task automatic chk(input string tag, input real got, input real exp, input real tol);
        n_cmp++;
        if (rabs(got - exp) > tol) begin
            n_err++;
            $display("FAIL %s: got %0.9f expected %0.9f (tol %0.1e)", tag, got, exp, tol);
        end
    endtask

    // Sample outputs 1 ps after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        real max_b;
        real min_b;
        real prev;
        real max_d;
        real max_o;
        real min_o;

        rst = 1'b1;
        en  = 1'b1;
        #1;
        chk("pre_edge", out_a, 0.0, 1e-12);
        chk("pre_edge_scl", out_b, 0.9, 1e-12);

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold", out_a, 0.0, 1e-12);
            chk("rst_hold_scl", out_b, 0.9, 1e-12);
        end

        rst   = 1'b0;
        max_b = -10.0;
        min_b = 10.0;
        for (int k = 1; k <= 100; k++) begin
            // A reset pulse between edges must be ignored.
            if (k == 33) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
            chk("wave", out_a, model(k, 1.0, 0.0), 1e-6);
            chk("wave_scl", out_b, model(k, 0.5, 0.9), 1e-6);
            if (out_b > max_b) max_b = out_b;
            if (out_b < min_b) min_b = out_b;
            if (k == 1)  chk("k1", out_a, 0.0627905, 1e-5);
            if (k == 25) chk("k25", out_a, 1.0, 1e-5);
            if (k == 25) chk("k25_scl", out_b, 1.4, 1e-5);
            if (k == 31) chk("k31", out_a, 0.9297765, 1e-5);
            if (k == 50) chk("k50", out_a, 0.0, 1e-5);
            if (k == 75) chk("k75", out_a, -1.0, 1e-5);
            if (k == 75) chk("k75_scl", out_b, 0.4, 1e-5);
            if (k == 30) begin
                chk("k30", out_a, 0.9510565, 1e-5);
                en = 1'b0;
                for (int h = 0; h < 10; h++) begin
                    tick();
                    chk("hold", out_a, 0.9510565, 1e-5);
                    chk("hold_scl", out_b, 0.9 + 0.5 * 0.9510565, 1e-5);
                end
                en = 1'b1;
            end
        end
        chk("scl_max", max_b, 1.4, 1e-6);
        chk("scl_min", min_b, 0.4, 1e-6);

        // Run further, then reset with en still high: reset must win.
        for (int k = 101; k <= 136; k++) tick();
        chk("pre_rst", out_a, model(136, 1.0, 0.0), 1e-6);
        rst = 1'b1;
        tick();
        chk("rst_mid", out_a, 0.0, 1e-12);
        chk("rst_mid_scl", out_b, 0.9, 1e-12);
        rst = 1'b0;
        tick();
        chk("restart_k1", out_a, 0.0627905, 1e-5);
        chk("restart_k1_scl", out_b, 0.9 + 0.5 * 0.0627905, 1e-5);

        // Long run across many accumulator wraps.
        prev  = out_a;
        max_d = 0.0;
        max_o = -10.0;
        min_o = 10.0;
        for (int k = 2; k <= 10001; k++) begin
            tick();
            if (rabs(out_a - prev) > max_d) max_d = rabs(out_a - prev);
            if (out_a > max_o) max_o = out_a;
            if (out_a < min_o) min_o = out_a;
            prev = out_a;
        end
        chk("long_end", out_a, model(10001, 1.0, 0.0), 1e-6);
        // Largest step is 2*sin(pi/100)*cos(pi/100) ~= 0.062791.
        chk("max_step", max_d, 0.062791, 5e-5);
        chk("long_max", max_o, 1.0, 1e-5);
        chk("long_min", min_o, -1.0, 1e-5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
